// File: rtl/chebyshev_clenshaw_engine_pkg.sv
// chebyshev_pkg: shared types and arithmetic helpers for the Clenshaw engine.
//   state_t      : engine FSM states (IDLE, ITER, FINAL, HOLD)
//   bw_of        : recurrence register width (CL + GUARD)
//   addr_w       : coefficient index width for a given ORDER
//   round_shift  : arithmetic right shift, truncating or rounding half-up
//   saturate     : clamp to a signed w-bit range
// Build option: CHEB_ROUND_EN selects round-half-up on every requantising
// shift; when undefined all shifts truncate toward -inf.
// The helpers work on 64-bit signed values; WL+1+CL+GUARD must stay below 64.
package chebyshev_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINAL,
        HOLD
    } state_t;

`ifdef CHEB_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    function automatic int unsigned bw_of(input int unsigned cl, input int unsigned guard);
        return cl + guard;
    endfunction

    function automatic int unsigned addr_w(input int unsigned order);
        return (order < 1) ? 1 : $clog2(order + 1);
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int unsigned s,
                                                       input bit rnd);
        logic signed [63:0] b;
        b = v;
        if (rnd && (s != 0)) begin
            b = v + (64'sd1 <<< (s - 1));
        end
        return b >>> s;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/chebyshev_clenshaw_engine_if.sv
// chebyshev_clenshaw_engine_if: coefficient write port plus x / f(x)
// valid-ready handshakes of the Clenshaw engine.
//   coeff_we, coeff_addr, coeff_in : coefficient bank write port
//   in_valid, in_ready, data_in    : x input handshake
//   out_valid, out_ready, data_out : f(x) output handshake
//   busy                           : engine in ITER or FINAL
// slave modport: the engine; master modport: producer/consumer side.
interface chebyshev_clenshaw_engine_if
    import chebyshev_pkg::*;
#(
    parameter int unsigned WL    = 16,
    parameter int unsigned CL    = 16,
    parameter int unsigned ORDER = 7
);
    localparam int unsigned AW = addr_w(ORDER);

    logic                 coeff_we;
    logic [AW-1:0]        coeff_addr;
    logic signed [CL-1:0] coeff_in;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [WL-1:0] data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WL-1:0] data_out;
    logic                 busy;

    modport slave (
        input  coeff_we, coeff_addr, coeff_in, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, busy
    );

    modport master (
        output coeff_we, coeff_addr, coeff_in, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

endinterface

// File: rtl/chebyshev_clenshaw_engine_requant.sv
// cheb_requant_sat: arithmetic right shift by SHIFT, then saturate to OW bits.
//   din  : IW-bit signed input
//   dout : OW-bit signed, shifted and saturated result
// With CHEB_ROUND_EN defined the shift rounds half-up, otherwise it
// truncates toward -inf. SHIFT = 0 is a pure saturator.
module cheb_requant_sat
    import chebyshev_pkg::*;
#(
    parameter int unsigned IW    = 32,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned OW    = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    always_comb begin
        dout = OW'(saturate(round_shift(64'(din), SHIFT, ROUND_EN), OW));
    end

endmodule

// File: rtl/chebyshev_clenshaw_engine.sv
// chebyshev_clenshaw_engine: evaluates f(x) = sum c_k*T_k(x), k = 0..ORDER,
// with the Clenshaw recurrence, one step per cycle on one shared multiplier.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset (clears FSM, bank, recurrence)
//   bus    : chebyshev_clenshaw_engine_if.slave (coefficient writes,
//            x in / f(x) out handshakes, busy)
// x and data_out are Q2.(WL-2); coefficients Q2.(CL-2); recurrence registers
// carry GUARD extra integer bits. Result latency: out_valid rises after edge
// ORDER+1 counted from the accept edge.
// Build option: CHEB_ROUND_EN (round half-up instead of truncation).
module chebyshev_clenshaw_engine
    import chebyshev_pkg::*;
#(
    parameter int unsigned WL    = 16,
    parameter int unsigned CL    = 16,
    parameter int unsigned ORDER = 7,
    parameter int unsigned GUARD = 4
) (
    input logic                        clock,
    input logic                        resetn,
    chebyshev_clenshaw_engine_if.slave bus
);

    localparam int unsigned BW = bw_of(CL, GUARD);
    localparam int unsigned SW = BW + 4;         // sum width, never wraps before saturation
    localparam int unsigned PW = WL + 1 + BW;    // full product width
    localparam int unsigned AW = addr_w(ORDER);

    state_t state, state_nx;

    logic signed [CL-1:0] bank [ORDER+1];
    logic signed [WL-1:0] x_q;
    logic signed [BW-1:0] b1, b2;
    logic [AW-1:0]        k;
    logic signed [WL-1:0] dout_q;

    logic signed [WL:0]   op_a;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] term;
    logic signed [CL-1:0] c_sel;
    logic signed [SW-1:0] sum;
    logic signed [BW-1:0] b_new;
    logic signed [WL-1:0] r_out;

    logic accept;
    logic wr_ok;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = ITER;
            ITER:    if (k == AW'(1)) state_nx = FINAL;
            FINAL:   state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state == ITER) || (state == FINAL);
        bus.out_valid = (state == HOLD);
        bus.data_out  = dout_q;
    end

    assign accept = (state == IDLE) && bus.in_valid;
    assign wr_ok  = (state == IDLE) && bus.coeff_we &&
                    ({1'b0, bus.coeff_addr} <= (AW+1)'(ORDER));

    // ---------------- datapath ----------------
    // The 2x of the recurrence is folded into the multiplier operand so a
    // single shift of WL-2 serves ITER and FINAL; this equals shifting x*b1
    // by WL-3, rounding bias included.
    always_comb begin
        op_a  = (state == ITER) ? {x_q, 1'b0} : {x_q[WL-1], x_q};
        prod  = PW'(op_a) * PW'(b1);
        c_sel = (state == ITER) ? bank[k] : bank[0];
        sum   = term - SW'(b2) + SW'(c_sel);
    end

    cheb_requant_sat #(.IW(PW), .SHIFT(WL - 2), .OW(SW)) u_prod (
        .din  (prod),
        .dout (term)
    );

    cheb_requant_sat #(.IW(SW), .SHIFT(0), .OW(BW)) u_rec (
        .din  (sum),
        .dout (b_new)
    );

    cheb_requant_sat #(.IW(SW), .SHIFT(CL - WL), .OW(WL)) u_out (
        .din  (sum),
        .dout (r_out)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            b1     <= '0;
            b2     <= '0;
            k      <= '0;
            dout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q <= bus.data_in;
                        k   <= AW'(ORDER);
                        b1  <= '0;
                        b2  <= '0;
                    end
                end
                ITER: begin
                    b2 <= b1;
                    b1 <= b_new;
                    k  <= k - AW'(1);
                end
                FINAL: begin
                    dout_q <= r_out;
                end
                default: ;
            endcase
        end
    end

    // Bank writes only land in IDLE, so a write coinciding with an accept is
    // visible to the first ITER step.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i <= ORDER; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_ok) begin
            bank[bus.coeff_addr] <= bus.coeff_in;
        end
    end

endmodule

// File: tb/tb_chebyshev_clenshaw_engine.sv
// Scoreboard bench for chebyshev_clenshaw_engine, WL=CL=16, ORDER=3, GUARD=4
// (1.0 = 0x4000). Expected results are queued at issue and checked by a
// monitor on each output handshake. Honours CHEB_ROUND_EN for the rounding case.
module tb_chebyshev_clenshaw_engine;

    localparam int unsigned WL    = 16;
    localparam int unsigned CL    = 16;
    localparam int unsigned ORDER = 3;
    localparam int unsigned GUARD = 4;

`ifdef CHEB_ROUND_EN
    localparam logic [15:0] RND_EXP = 16'h0001;
`else
    localparam logic [15:0] RND_EXP = 16'h0000;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    chebyshev_clenshaw_engine_if #(.WL(WL), .CL(CL), .ORDER(ORDER)) bus ();

    chebyshev_clenshaw_engine #(
        .WL    (WL),
        .CL    (CL),
        .ORDER (ORDER),
        .GUARD (GUARD)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int npass = 0;
    int ntot  = 0;

    logic [15:0] exp_q [$];
    string       nm_q  [$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        ntot++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, expv);
    endtask

    task automatic chkb(input string nm, input logic act, input logic expv);
        ntot++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, expv);
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clock) begin
        logic [15:0] v;
        string       n;
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                ntot++;
                $display("FAIL unexpected_out: data_out=%h, expected no result", bus.data_out);
            end else begin
                v = exp_q.pop_front();
                n = nm_q.pop_front();
                chk(n, bus.data_out, v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] v);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = a;
        bus.coeff_in   = v;
        tick();
        bus.coeff_we   = 1'b0;
    endtask

    task automatic load(input logic [15:0] c0, input logic [15:0] c1,
                        input logic [15:0] c2, input logic [15:0] c3);
        wr(2'd0, c0);
        wr(2'd1, c1);
        wr(2'd2, c2);
        wr(2'd3, c3);
    endtask

    task automatic accept(input logic [15:0] x, input string nm);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chkb({nm, "_ready"}, bus.in_ready, 1'b1);
        bus.data_in  = x;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.data_in  = 16'h7777;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input logic [15:0] x, input logic [15:0] expv, input string nm);
        int lat;
        exp_q.push_back(expv);
        nm_q.push_back(nm);
        accept(x, nm);
        wait_valid(lat);
        chk({nm, "_latency"}, 16'(lat), 16'(ORDER + 1));
        tick();
        chkb({nm, "_idle_after"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        int lat;

        bus.coeff_we   = 1'b0;
        bus.coeff_addr = '0;
        bus.coeff_in   = '0;
        bus.in_valid   = 1'b0;
        bus.data_in    = '0;
        bus.out_ready  = 1'b1;

        // reset state
        repeat (3) tick();
        chkb("rst_out_valid", bus.out_valid, 1'b0);
        chkb("rst_busy", bus.busy, 1'b0);
        chk("rst_data_out", bus.data_out, 16'h0000);
        resetn = 1'b1;
        tick();
        chkb("rst_in_ready", bus.in_ready, 1'b1);

        // T1 and T3
        load(16'h0000, 16'h4000, 16'h0000, 16'h0000);
        run(16'h2000, 16'h2000, "T1");
        load(16'h0000, 16'h0000, 16'h0000, 16'h4000);
        run(16'h2000, 16'hC000, "T3");

        // saturation both ways
        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(16'h4000, 16'h7FFF, "sat_pos");
        load(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run(16'h4000, 16'h8000, "sat_neg");

        // backpressure; a coefficient write while holding must be dropped
        load(16'h0000, 16'h4000, 16'h0000, 16'h0000);
        bus.out_ready = 1'b0;
        exp_q.push_back(16'h2000);
        nm_q.push_back("bp_result");
        accept(16'h2000, "bp");
        wait_valid(lat);
        chk("bp_latency", 16'(lat), 16'(ORDER + 1));
        for (int i = 0; i < 5; i++) begin
            chk("bp_data_stable", bus.data_out, 16'h2000);
            chkb("bp_in_ready_low", bus.in_ready, 1'b0);
            chkb("bp_valid_held", bus.out_valid, 1'b1);
            if (i == 0) begin
                bus.coeff_we   = 1'b1;
                bus.coeff_addr = 2'd0;
                bus.coeff_in   = 16'h4000;
            end
            tick();
            bus.coeff_we = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        chkb("bp_in_ready_release", bus.in_ready, 1'b1);
        chkb("bp_valid_drop", bus.out_valid, 1'b0);
        run(16'h2000, 16'h2000, "bp_rerun");

        // write and accept in the same IDLE cycle: new c3 must be used
        load(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        exp_q.push_back(16'hC000);
        nm_q.push_back("wr_accept_same");
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 2'd3;
        bus.coeff_in   = 16'h4000;
        bus.data_in    = 16'h2000;
        bus.in_valid   = 1'b1;
        tick();
        bus.coeff_we   = 1'b0;
        bus.in_valid   = 1'b0;
        wait_valid(lat);
        chk("wr_accept_same_latency", 16'(lat), 16'(ORDER + 1));
        tick();

        // reset in the middle of ITER
        load(16'h0000, 16'h4000, 16'h0000, 16'h0000);
        accept(16'h2000, "rst_mid");
        chkb("rst_mid_busy_iter", bus.busy, 1'b1);
        tick();
        resetn = 1'b0;
        #1;
        chkb("rst_mid_out_valid", bus.out_valid, 1'b0);
        chkb("rst_mid_busy", bus.busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chkb("rst_mid_no_valid", bus.out_valid, 1'b0);
        end
        resetn = 1'b1;
        tick();
        run(16'h2000, 16'h0000, "rst_bank_cleared");

        // rounding on the output of x*b1
        load(16'h0000, 16'h2000, 16'h0000, 16'h0000);
        run(16'h0001, RND_EXP, "round");

        repeat (3) tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
